// File: rtl/spec_ram_reader_if.sv
// Result stream from the spectrum RAM reader: one bin per beat, valid/ready handshake.
interface spec_ram_reader_if #(
   parameter int AW = 12,
   parameter int DW = 16
);
   logic          m_valid;
   logic          m_ready;
   logic [AW-1:0] m_addr;
   logic [DW:0]   m_mag;
   logic          m_last;

   modport master (output m_valid, m_addr, m_mag, m_last, input m_ready);
   modport slave  (input m_valid, m_addr, m_mag, m_last, output m_ready);
endinterface

// File: rtl/spec_ram_reader.sv
// Sweeps the learned real/imag spectrum RAMs and streams an approximate magnitude per bin.
// Optional peak-bin tracking is built when SPEC_READER_PEAK_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start or a learn_done rising edge
// S_SCAN  | issuing RAM addresses 0..DEPTH-1 under FIFO credit
// S_DRAIN | all addresses issued, waiting for pipeline and FIFO to empty
// S_FIN   | one-cycle done pulse
module spec_ram_reader #(
   parameter int DEPTH      = 2800,
   parameter int AW         = 12,
   parameter int DW         = 16,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_50m,
   input  logic                 rst_n,
   input  logic                 learn_done,
   input  logic                 start,
   output logic [AW-1:0]        real_addr,
   output logic [AW-1:0]        imag_addr,
   input  logic signed [DW-1:0] rd_real,
   input  logic signed [DW-1:0] rd_imag,
   spec_ram_reader_if.master    m,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        peak_addr,
   output logic [DW:0]          peak_mag
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [CW:0]   CREDITS   = (CW+1)'(FIFO_DEPTH);
   localparam logic [DW-1:0] MOST_NEG  = {1'b1, {(DW-1){1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]    state;
   logic          learn_s1, learn_s2, learn_s3;
   logic          trigger, issue, push, pop;
   logic [AW-1:0] addr_q;
   logic [RD_LAT-1:0] tag_vld;
   logic [AW-1:0] tag_addr [RD_LAT];
   logic          mag_vld;
   logic [AW-1:0] mag_addr;
   logic [DW:0]   mag_val;
   logic [DW-2:0] abs_re, abs_im, mag_hi, mag_lo;
   logic [DW:0]   mag_next;
   logic [CW-1:0] in_flight, fifo_count;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [AW-1:0] fifo_addr [FIFO_DEPTH];
   logic [DW:0]   fifo_mag  [FIFO_DEPTH];

   function automatic logic [DW-2:0] sat_abs(input logic signed [DW-1:0] v);
      if (!v[DW-1])
         sat_abs = v[DW-2:0];
      else if (v == MOST_NEG)
         sat_abs = '1;
      else
         sat_abs = (DW-1)'(-v);
   endfunction

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      ptr_next = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         learn_s1 <= 1'b0;
         learn_s2 <= 1'b0;
         learn_s3 <= 1'b0;
      end else begin
         learn_s1 <= learn_done;
         learn_s2 <= learn_s1;
         learn_s3 <= learn_s2;
      end
   end

   assign trigger = (state == S_IDLE) && (start || (learn_s2 && !learn_s3));
   assign pop     = m.m_valid && m.m_ready;
   // A beat leaving this cycle frees its slot, so count it as credit to keep one issue per cycle.
   assign issue   = (state == S_SCAN) &&
                    (({1'b0, in_flight} + {1'b0, fifo_count}) < (CREDITS + {{CW{1'b0}}, pop}));

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         addr_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (trigger) begin
               state  <= S_SCAN;
               addr_q <= '0;
            end
            S_SCAN: if (issue) begin
               if (addr_q == LAST_ADDR) state <= S_DRAIN;
               else                     addr_q <= addr_q + AW'(1);
            end
            S_DRAIN: if (in_flight == '0 && fifo_count == '0) state <= S_FIN;
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_addr[i] <= '0;
      end else begin
         tag_vld[0]  <= issue;
         tag_addr[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_addr[i] <= tag_addr[i-1];
         end
      end
   end

   // max + min/2 of the saturated magnitudes; DW+1 bits always suffices.
   always_comb begin
      abs_re = sat_abs(rd_real);
      abs_im = sat_abs(rd_imag);
      mag_hi = abs_re;
      mag_lo = abs_im;
      if (abs_im > abs_re) begin
         mag_hi = abs_im;
         mag_lo = abs_re;
      end
      mag_next = {2'b00, mag_hi} + {3'b000, mag_lo[DW-2:1]};
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         mag_vld  <= 1'b0;
         mag_addr <= '0;
         mag_val  <= '0;
      end else begin
         mag_vld  <= tag_vld[RD_LAT-1];
         mag_addr <= tag_addr[RD_LAT-1];
         mag_val  <= mag_next;
      end
   end

   assign push = mag_vld;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) in_flight <= '0;
      else        in_flight <= in_flight + CW'(issue) - CW'(push);
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr[i] <= '0;
            fifo_mag[i]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_addr[wr_ptr] <= mag_addr;
            fifo_mag[wr_ptr]  <= mag_val;
            wr_ptr            <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   assign m.m_valid = (fifo_count != '0);
   assign m.m_addr  = fifo_addr[rd_ptr];
   assign m.m_mag   = fifo_mag[rd_ptr];
   assign m.m_last  = m.m_valid && (fifo_addr[rd_ptr] == LAST_ADDR);

   assign real_addr = addr_q;
   assign imag_addr = addr_q;
   assign busy      = (state == S_SCAN) || (state == S_DRAIN);
   assign done      = (state == S_FIN);

`ifdef SPEC_READER_PEAK_EN
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         peak_addr <= '0;
         peak_mag  <= '0;
      end else if (trigger) begin
         peak_addr <= '0;
         peak_mag  <= '0;
      end else if (push && (mag_val > peak_mag)) begin
         peak_addr <= mag_addr;
         peak_mag  <= mag_val;
      end
   end
`else
   assign peak_addr = '0;
   assign peak_mag  = '0;
`endif

endmodule

// File: doc/spec_ram_reader.md
Name: spec_ram_reader

Overview:
- Reader side of the learned-spectrum RAM pair (real and imag, 2800x16 each). The learning path writes these RAMs on clk_1_6384m.
- After learning completes, this block sweeps the clk_50m read port of both RAMs and computes an approximate magnitude per bin.
- Results stream out on a valid/ready interface for downstream filter synthesis and display.
- Optionally tracks the peak bin over each sweep.

Parameters:
- DEPTH, 2800: number of bins swept (addresses 0..DEPTH-1).
- AW, 12: RAM address width.
- DW, 16: RAM data width, signed two's complement.
- RD_LAT, 2: RAM read latency in clk_50m cycles, from address to doutb.
- FIFO_DEPTH, 4: output skid FIFO entries; must be >= RD_LAT+1.

Ports:
- clk_50m  in  1  system clock
- rst_n  in  1  async active-low reset
- learn_done  in  1  level from the learning path (other clock domain); 2-flop synchronised internally
- start  in  1  single-cycle manual sweep request, clk_50m domain
- real_addr  out  AW  real RAM read address
- imag_addr  out  AW  imag RAM read address; always equal to real_addr
- rd_real  in  DW  real RAM doutb
- rd_imag  in  DW  imag RAM doutb
- m_valid  out  1  stream data valid
- m_ready  in  1  stream sink ready
- m_addr  out  AW  bin index of the current beat
- m_mag  out  DW+1  magnitude of the current beat
- m_last  out  1  high on the beat for bin DEPTH-1
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep is fully drained
- peak_addr  out  AW  bin index of the maximum magnitude (optional feature)
- peak_mag  out  DW+1  maximum magnitude (optional feature)

Behaviour:
- Reset is asynchronous on rst_n, active-low; clock is clk_50m.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, in-flight count 0, synchroniser flops 0.

Trigger:
- A sweep is requested by a rising edge of synchronised learn_done, or by start=1.
- A trigger is accepted only in IDLE. Triggers while busy=1 are dropped, not queued.
- learn_done held high does not retrigger; a new rising edge is required.

FSM: IDLE -> SCAN -> DRAIN -> FIN -> IDLE.
- IDLE: busy=0. On trigger go to SCAN, set addr=0, clear the peak registers.
- SCAN: busy=1.
  - Issue one address per cycle when (in_flight + fifo_count) < FIFO_DEPTH. Otherwise hold the address; this is the credit scheme, so the FIFO never overflows.
  - After issuing DEPTH-1, go to DRAIN.
- DRAIN: busy=1. Wait until in_flight==0 and the FIFO is empty with its last beat accepted.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.

Read pipeline:
- Issued addresses are tracked in an RD_LAT-deep tag shift register.
- Data returning RD_LAT cycles after issue is paired with its tag, then the magnitude is registered (1 cycle) before the FIFO push.
- in_flight counts issued-but-not-pushed entries; it covers RD_LAT+1 stages.

Magnitude:
- a=|rd_real|, b=|rd_imag|. abs(-32768) saturates to 32767.
- m_mag = max(a,b) + (min(a,b)>>1), unsigned DW+1 bits; it cannot overflow.

Stream:
- m_valid=1 whenever the FIFO is non-empty. A beat transfers when m_valid&m_ready.
- m_addr, m_mag and m_last stay stable while m_valid=1 and m_ready=0.
- Bins are output strictly in order 0..DEPTH-1, exactly once each.
- With m_ready held at 1 from the trigger, the first beat appears RD_LAT+3 cycles after the trigger cycle (1 cycle synchroniser-edge/FSM, RD_LAT, 1 mag, 1 FIFO). Throughput is then 1 beat per cycle.
- Simultaneous FIFO push and pop in the same cycle leaves fifo_count unchanged.

Reset mid-sweep:
- Everything returns to reset values immediately.
- Partial results are discarded and done is not pulsed.

Optional Feature:
- Macro: SPEC_READER_PEAK_EN.
- Defined:
  - At each FIFO push, if mag > peak_mag (strictly greater), update peak_mag and peak_addr. Ties keep the lowest index.
  - Both registers are cleared to 0 at sweep start.
  - Values are final and stable from the done cycle until the next trigger.
- Undefined:
  - peak_addr and peak_mag are tied to 0 and the compare logic is absent.
  - The stream interface is unchanged.

Test Plan:
- RAM model with RD_LAT=2, rd_real=addr, rd_imag=0, m_ready=1, pulse start:
  - 2800 beats with m_addr 0..2799 and m_mag==addr, contiguous one per cycle.
  - m_last only on beat 2799; done pulses once after it; busy is low thereafter.
- rd_real=-32768, rd_imag=-32768 at bin 5, zeros elsewhere:
  - m_mag[5] = 32767+16383 = 49150; all other bins 0.
  - With SPEC_READER_PEAK_EN: peak_addr=5, peak_mag=49150.
- Random m_ready (50% duty) plus 20-cycle stalls:
  - No beat lost or duplicated; outputs hold stable while stalled.
  - FIFO count never exceeds 4; in-order sequence matches the model.
- Drive learn_done 0->1 through the synchroniser and hold it high for 10000 cycles, also pulsing start mid-sweep:
  - Exactly one sweep runs; the mid-sweep start is ignored.
  - A new learn_done 0->1 edge after FIN starts a second sweep with the peak registers cleared.
- Assert rst_n=0 at beat 1000:
  - All outputs 0 asynchronously; no done pulse.
  - After release, a start pulse produces a full clean 2800-beat sweep from bin 0.
- Equal peaks at bins 10 and 20 (m_mag=1000), build with SPEC_READER_PEAK_EN:
  - peak_addr=10.
- Same stimulus, build without the macro:
  - peak outputs stay 0.
